// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
// Single-port word memory that answers load/store/fetch requests from the
// multicycle CPU control path. Each request gets one registered response
// after a fixed number of wait states. Misaligned and out-of-range
// addresses are flagged with resp_err instead of aliasing into the array.
//
// Parameters
//   ADDR_W      word-address width, memory holds 2**ADDR_W 32-bit words
//   WAIT_CYCLES wait states per access (0..15)
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   request handshake, accepted when both are high
//   req_we                1 = store, 0 = load/fetch
//   req_addr, req_wdata   byte address and store data
//   resp_valid            one-cycle response strobe
//   resp_rdata, resp_err  load data (0 for stores/faults) and fault flag
//   busy                  request in flight
//
// Optional feature (macro MEM_STATS_EN)
//   rd_count, wr_count, err_count: 16-bit wrapping counters of successful
//   loads, successful stores and faulted requests.
// ---------------------------------------------------------------------------
module mem_responder #(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        busy
`ifdef MEM_STATS_EN
   ,
   output logic [15:0] rd_count,
   output logic [15:0] wr_count,
   output logic [15:0] err_count
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);
   localparam logic [3:0] WAIT_INIT = ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        resp_valid_q;
   logic [31:0] rdata_q;
   logic        err_q;

   logic [31:0] mem [2**ADDR_W];

   logic              accept;
   logic              access;
   logic              accWe;
   logic [31:0]       accAddr;
   logic [31:0]       accWdata;
   logic              fault;
   logic [ADDR_W-1:0] idx;

   assign req_ready  = (state_q == IDLE) & ~reset;
   assign busy       = (state_q != IDLE);
   assign accept     = req_valid & req_ready;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

   // With zero wait states the access happens on the accept edge itself,
   // so the operands come straight from the request ports; otherwise they
   // come from the copy latched at accept time.
   always_comb begin
      accWe    = we_q;
      accAddr  = addr_q;
      accWdata = wdata_q;
      if (state_q == IDLE) begin
         accWe    = req_we;
         accAddr  = req_addr;
         accWdata = req_wdata;
      end
   end

   // Anything above the memory's word range is a fault, not an alias.
   always_comb begin
      fault = (accAddr[1:0] != 2'b00) || ((accAddr >> (ADDR_W + 2)) != 32'd0);
      idx   = accAddr[ADDR_W+1:2];
   end

   // Next-state logic. 'access' marks the single edge on which memory is
   // touched and the response registers are loaded.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      access  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (ZERO_WAIT) begin
                  access  = 1'b1;
                  state_d = RESP;
               end else begin
                  cnt_d   = WAIT_INIT;
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               access  = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, counter and response registers. resp_rdata/resp_err keep their
   // value between access edges; resp_valid follows 'access' so it is high
   // for exactly the one cycle spent in RESP.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= 4'd0;
         resp_valid_q <= 1'b0;
         rdata_q      <= 32'd0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         resp_valid_q <= access;
         if (access) begin
            rdata_q <= (!accWe && !fault) ? mem[idx] : 32'd0;
            err_q   <= fault;
         end
      end
   end

   // Request capture. Only the accept edge loads these, so anything on the
   // request ports while busy is ignored.
   always_ff @(posedge clk) begin
      if (accept) begin
         we_q    <= req_we;
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
      end
   end

   // Memory array is intentionally not reset. Reset wins over a pending
   // access, which is what drops a store caught in WAIT.
   always_ff @(posedge clk) begin
      if (!reset && access && accWe && !fault) begin
         mem[idx] <= accWdata;
      end
   end

`ifdef MEM_STATS_EN
   // Access statistics, counted on the access edge and wrapping at 2**16.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_count  <= 16'd0;
         wr_count  <= 16'd0;
         err_count <= 16'd0;
      end else if (access) begin
         if (fault) begin
            err_count <= err_count + 16'd1;
         end else if (accWe) begin
            wr_count <= wr_count + 16'd1;
         end else begin
            rd_count <= rd_count + 16'd1;
         end
      end
   end
`endif

endmodule
